// File: rtl/regdst_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regdst_scoreboard
// Description : Selects the write-destination register and tracks in-flight
//               destinations in an in-order queue for busy/hazard queries.
//               Optional macro REGDST_ZERO_GUARD_EN: register 0 is never
//               queued and never reported busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regdst_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int SP_REG = 29,
    parameter int RA_REG = 31
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 select,
    input  logic [ADDR_W-1:0]          in_rt,
    input  logic [ADDR_W-1:0]          in_rd,
    input  logic [ADDR_W-1:0]          in_rs,
    input  logic                       issue,
    output logic                       issue_ready,
    input  logic                       retire,
    output logic [ADDR_W-1:0]          dst_sel,
    output logic [ADDR_W-1:0]          head_dst,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          query_a,
    input  logic [ADDR_W-1:0]          query_b,
    output logic                       busy_a,
    output logic                       busy_b,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    logic              w_nonempty;
    logic              w_zero_skip;
    logic              w_push;
    logic              w_pop;
    logic              w_err_set;
    logic              w_qa_ok;
    logic              w_qb_ok;
    logic [DEPTH-1:0]  w_hit_a;
    logic [DEPTH-1:0]  w_hit_b;

    always_comb begin
        dst_sel = '0;
        case (select)
            3'b000:  dst_sel = in_rt;
            3'b001:  dst_sel = ADDR_W'(SP_REG);
            3'b010:  dst_sel = ADDR_W'(RA_REG);
            3'b011:  dst_sel = in_rd;
            3'b100:  dst_sel = in_rs;
            default: dst_sel = '0;
        endcase
    end

`ifdef REGDST_ZERO_GUARD_EN
    assign w_zero_skip = (dst_sel == '0);
    assign w_qa_ok     = (query_a != '0);
    assign w_qb_ok     = (query_b != '0);
`else
    assign w_zero_skip = 1'b0;
    assign w_qa_ok     = 1'b1;
    assign w_qb_ok     = 1'b1;
`endif

    assign w_nonempty  = (r_count != '0);
    assign issue_ready = (r_count != C_DEPTH) || retire;
    assign w_push      = issue && issue_ready && !w_zero_skip;
    assign w_pop       = retire && w_nonempty;
    // A zero destination under the guard counts as accepted, so it never flags err.
    assign w_err_set   = (retire && !w_nonempty) ||
                         (issue && !issue_ready && !w_zero_skip);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_slot
            logic [PTR_W-1:0] w_off;
            logic             w_occ;
            // Slot is occupied when its distance from the read pointer is below count.
            assign w_off      = PTR_W'(gi) - r_rptr;
            assign w_occ      = ({1'b0, w_off} < r_count);
            assign w_hit_a[gi] = w_occ && (r_mem[gi] == query_a);
            assign w_hit_b[gi] = w_occ && (r_mem[gi] == query_b);
        end
    endgenerate

    assign busy_a     = (|w_hit_a) && w_qa_ok;
    assign busy_b     = (|w_hit_b) && w_qb_ok;
    assign head_valid = w_nonempty;
    assign head_dst   = w_nonempty ? r_mem[r_rptr] : '0;
    assign count      = r_count;
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= dst_sel;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/regdst_scoreboard.md
# regdst_scoreboard

Parametrised successor to the MIPS write-destination selector. It selects the destination register number from rt, rd, rs or the fixed $sp/$ra constants. On each issue it records that number in an in-order in-flight queue and answers combinational "register busy" queries for the hazard/stall logic. The control unit drives it on instruction issue, and the register-file write stage retires entries in order.

## Interface
- `ADDR_W`, 5: register-number width.
- `DEPTH`, 4: in-flight queue entries; power of two, ≥2.
- `SP_REG`, 29: constant destination for select 3'b001.
- `RA_REG`, 31: constant destination for select 3'b010.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `select`  in  3  destination source: 000 rt, 001 SP_REG, 010 RA_REG, 011 rd, 100 rs, 101–111 register 0.
- `in_rt`, `in_rd`, `in_rs`  in  ADDR_W each  candidate register numbers.
- `issue`  in  1  push the selected destination this cycle.
- `issue_ready`  out  1  push accepted this cycle.
- `retire`  in  1  pop the oldest entry (its write has completed).
- `dst_sel`  out  ADDR_W  combinational selected destination.
- `head_dst`  out  ADDR_W  oldest in-flight destination; 0 when empty.
- `head_valid`  out  1  queue non-empty.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `query_a`, `query_b`  in  ADDR_W  registers read by the next instruction.
- `busy_a`, `busy_b`  out  1  queried register matches any occupied entry.
- `err`  out  1  sticky: retire on empty, or issue while not ready.

## Operation
- `dst_sel` is purely combinational from `select` and the inputs. Codes 101–111 give 0.
- Queue: circular buffer with write pointer, read pointer and count; pointers wrap modulo DEPTH.
- `issue_ready` = (count < DEPTH) or `retire`. A full queue accepts an issue when it retires in the same cycle.
- Accepted issue: `dst_sel` is written at the write pointer, the pointer advances, and count increments.
- `retire` with count > 0: the read pointer advances and count decrements.
- Simultaneous accepted issue and retire: both pointers advance and count is unchanged. This holds at count = 1, where the new entry becomes the head next cycle.
- `retire` at count 0: no state change; `err` is set.
- `issue` while `issue_ready` = 0: entry dropped, no state change; `err` is set.
- `busy_x` = OR over occupied entries of (entry == query_x). It is computed from registered state only, so an entry issued this cycle is not visible until the next cycle. The entry retiring this cycle still reports busy in this cycle.
- `err` clears only on `reset`.

## Timing
- Reset values: count 0, pointers 0, `head_valid` 0, `head_dst` 0, `issue_ready` 1, `busy_a`/`busy_b` 0, `err` 0. Entry storage is also cleared to 0.
- `reset` asserted mid-operation discards all entries at that edge. `issue`/`retire` in a reset cycle are ignored.
- Latency from issue to `head_dst`/`busy`: 1 cycle.
- Latency from retire to the busy bit clearing: 1 cycle.
- `dst_sel`, `issue_ready`, `busy_x`: combinational, with no path from `issue` to `busy_x`.
- `count` and `head_*` are registered-state outputs.

## Configuration
- `REGDST_ZERO_GUARD_EN` defined:
  - An issue whose `dst_sel` is 0 is accepted (`issue_ready` unaffected, no `err`) but not pushed, so count is unchanged.
  - Queries for register 0 always return busy = 0.
- Undefined: register 0 is treated like any other register: pushed, counted, and reported busy.

## Test plan
- Reset, then issue select 001, 010, 011 (rd = 7), 100 (rs = 3) on consecutive cycles.
  - Required: count 4, `issue_ready` 0, head 29.
  - `busy` true for queries 29/31/7/3 and false for 8.
- Full queue (DEPTH = 4), issue + retire in the same cycle with select 000 (rt = 12).
  - Required: count stays 4 and head becomes 31.
  - Query 29 is busy in the issue cycle and clear the next cycle; query 12 becomes busy the next cycle.
- Empty queue, `retire` pulse → `err` = 1, count 0, `head_valid` 0. `err` stays set until `reset`.
- Issue DEPTH+3 entries, interleaving retires → pointers wrap and `head_dst` follows FIFO order exactly.
- Issue select 110 → `dst_sel` 0.
  - With `REGDST_ZERO_GUARD_EN`: count unchanged and query 0 is not busy.
  - Without it: count +1 and query 0 is busy.
- Assert `reset` with count 3 while issuing → next cycle count 0, all `busy` 0, `issue_ready` 1, `err` 0.
